gray_to_binary_serial: RTL and testbench
========================================

GRAY_TO_BINARY_SERIAL -- requirements
Module: gray_to_binary_serial

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the code width in bits (legal range 1..32).
REQ-002 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1, SHALL be the reset: synchronous, active-high.
REQ-004 Port in_valid, input, 1, SHALL indicate in_gray holds a code to decode.
REQ-005 Port in_ready, output, 1, SHALL indicate the block accepts a code this cycle.
REQ-006 Port in_gray, input, WIDTH, SHALL be the Gray-coded input word.
REQ-007 Port out_valid, output, 1, SHALL indicate out_bin/out_step_err hold a completed result.
REQ-008 Port out_ready, input, 1, SHALL indicate the consumer takes the result this cycle.
REQ-009 Port out_bin, output, WIDTH, SHALL be the decoded binary word.
REQ-010 Port out_step_err, output, 1, SHALL flag a Gray-adjacency violation against the previously accepted code.

Function
REQ-011 FSM SHALL have states IDLE, SHIFT, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-012 IDLE: on in_valid=1, accept edge: capture in_gray, clear bin accumulator and running-XOR bit, load bit counter = WIDTH, go SHIFT; otherwise stay.
REQ-013 SHIFT: each edge SHALL produce one binary bit MSB first, b[i] = b[i+1] XOR g[i] (b[WIDTH] taken as 0), decrement counter.
REQ-014 SHIFT SHALL go to DONE on the edge that produces b[0]; out_valid SHALL rise exactly WIDTH edges after the accept edge.
REQ-015 DONE: out_bin, out_step_err SHALL be held stable while out_valid=1 and out_ready=0.
REQ-016 DONE: on out_ready=1, go IDLE on that edge; no new code accepted on that edge (throughput one code per WIDTH+2 cycles minimum).
REQ-017 Outside DONE, out_bin SHALL hold the last completed result (0 after reset).
REQ-018 Step check: at accept, out_step_err result = 1 iff a prior code was accepted since reset and popcount(in_gray XOR prev_gray) != 1; identical consecutive codes SHALL flag error.
REQ-019 Wrap-around (e.g. WIDTH=4, 1000 -> 0000) SHALL be treated as an ordinary single-bit step, no error.
REQ-020 First code after reset SHALL never flag error; prev_gray SHALL update at every accept.
REQ-021 in_gray changes while not in IDLE SHALL have no effect.

Reset
REQ-022 rst=1 at an edge SHALL force IDLE, out_valid=0, out_bin=0, out_step_err=0, counter=0, prev_gray=0, prev-seen flag=0, regardless of state.
REQ-023 rst asserted mid-SHIFT or in DONE SHALL discard the in-flight result; no out_valid pulse for it afterward.
REQ-024 in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-025 Package gray_pkg SHALL hold the FSM state encoding (IDLE/SHIFT/DONE) and the default WIDTH constant.
REQ-026 Sub-module gray_step_check (combinational: two WIDTH words in, single-bit-difference flag out) SHALL implement REQ-018; all else in the top module.

Verification (WIDTH=4)
REQ-027 Accept in_gray=0110, out_ready=1 -> out_valid high exactly 4 edges after accept, out_bin=0100, out_step_err=0.
REQ-028 Exhaustive: all 16 codes in binary-Gray order 0000,0001,0011,...,1000 -> out_bin = 0..15 in order, out_step_err=0 on every result.
REQ-029 Accept 0000 then 0011 -> second result out_bin=0010, out_step_err=1; then 0011 again -> out_step_err=1 (identical code).
REQ-030 Result 1000 with out_ready=0 for 5 cycles -> out_valid, out_bin=1111 stable all 5 cycles, in_ready=0; one cycle after out_ready=1, in_ready=1.
REQ-031 rst pulsed 2 edges after accepting 1010 -> no out_valid, out_bin=0, in_ready=1 next cycle; then accept 1111 -> out_bin=1010, out_step_err=0.
REQ-032 Accept 1000 then 0000 -> out_bin=1111 then 0000, out_step_err=0 both (wrap).

Source files
------------

// File: rtl/gray_pkg.sv
// Shared definitions for the serial Gray-to-binary decoder.
// FSM state encoding and default code width.
package gray_pkg;

    localparam int GRAY_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/gray_step_check.sv
// Flags whether two codes differ in exactly one bit position.
// Purely combinational.
module gray_step_check #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_cur,
    input  logic [WIDTH-1:0] i_prev,
    output logic             o_single
);

    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_low;

    assign w_diff = i_cur ^ i_prev;
    // Clearing the lowest set bit leaves zero only for a power of two.
    assign w_low  = w_diff & (w_diff - WIDTH'(1));
    assign o_single = (|w_diff) && !(|w_low);

endmodule

// File: rtl/gray_to_binary_serial.sv
// Serial Gray-to-binary decoder, one bit per cycle MSB first,
// with adjacency check against the previously accepted code.
module gray_to_binary_serial
    import gray_pkg::*;
#(
    parameter int WIDTH = GRAY_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_gray,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_bin,
    output logic             out_step_err
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_bin;
    logic [CW-1:0]    r_cnt;
    logic             r_xor;
    logic             r_seen;
    logic             r_err_pend;
    logic             r_err;
    logic             w_accept;
    logic             w_shift;
    logic             w_last;
    logic             w_bit;
    logic             w_single;
    logic [WIDTH-1:0] w_acc_nx;

    gray_step_check #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_cur    (in_gray),
        .i_prev   (r_prev),
        .o_single (w_single)
    );

    assign w_accept = (r_state == ST_IDLE) && in_valid;
    assign w_shift  = (r_state == ST_SHIFT);
    assign w_last   = w_shift && (r_cnt == CW'(1));
    // Running XOR of decoded bits so far is b[i+1].
    assign w_bit    = r_xor ^ r_sr[WIDTH-1];
    assign w_acc_nx = (r_acc << 1) | WIDTH'(w_bit);

    assign out_bin      = r_bin;
    assign out_step_err = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (r_cnt == CW'(1)) w_next = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr       <= '0;
            r_acc      <= '0;
            r_prev     <= '0;
            r_bin      <= '0;
            r_cnt      <= '0;
            r_xor      <= 1'b0;
            r_seen     <= 1'b0;
            r_err_pend <= 1'b0;
            r_err      <= 1'b0;
        end else if (w_accept) begin
            r_sr       <= in_gray;
            r_acc      <= '0;
            r_xor      <= 1'b0;
            r_cnt      <= CW'(WIDTH);
            r_prev     <= in_gray;
            r_seen     <= 1'b1;
            r_err_pend <= r_seen && !w_single;
        end else if (w_shift) begin
            r_sr  <= r_sr << 1;
            r_acc <= w_acc_nx;
            r_xor <= w_bit;
            r_cnt <= r_cnt - CW'(1);
            // Publish only on completion so out_bin holds the last result.
            if (w_last) begin
                r_bin <= w_acc_nx;
                r_err <= r_err_pend;
            end
        end
    end

endmodule

// File: tb/tb_gray_to_binary_serial.sv
// Directed and random checks of the serial Gray decoder
// against an arithmetic reference model.
module tb_gray_to_binary_serial;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_gray;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_bin;
    logic         out_step_err;

    int n_checks = 0;
    int n_errors = 0;

    logic         m_seen;
    logic [W-1:0] m_prev;
    logic [W-1:0] m_bin;
    logic         m_err;

    gray_to_binary_serial #(
        .WIDTH (W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_gray      (in_gray),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_bin      (out_bin),
        .out_step_err (out_step_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
        logic [W-1:0] b;
        b = '0;
        for (int i = 0; i < W; i++) b = b ^ (g >> i);
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_seen = 1'b0;
        m_prev = '0;
        m_bin  = '0;
        m_err  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_bin", 32'(out_bin), 32'd0);
        chk("rst_out_err", 32'(out_step_err), 32'd0);
    endtask

    task automatic model_accept(input logic [W-1:0] code,
                                output logic [W-1:0] eb,
                                output logic ee);
        eb = g2b(code);
        ee = m_seen && ($countones(code ^ m_prev) != 1);
        m_prev = code;
        m_seen = 1'b1;
    endtask

    task automatic do_code(input logic [W-1:0] code, input int hold);
        logic [W-1:0] eb;
        logic         ee;
        int           n;
        chk("idle_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_gray  = code;
        tick();
        model_accept(code, eb, ee);
        in_valid = 1'b0;
        in_gray  = W'($urandom);
        n = 0;
        while (!out_valid && n < W + 3) begin
            chk("busy_hold_bin", 32'(out_bin), 32'(m_bin));
            in_gray = W'($urandom);
            tick();
            n++;
        end
        chk("latency", 32'(n), 32'(W));
        chk("out_bin", 32'(out_bin), 32'(eb));
        chk("out_err", 32'(out_step_err), 32'(ee));
        m_bin = eb;
        m_err = ee;
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_bin", 32'(out_bin), 32'(eb));
            chk("stall_err", 32'(out_step_err), 32'(ee));
            chk("stall_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_gray   = W'($urandom);
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("drain_ready", 32'(in_ready), 32'd1);
        chk("drain_bin", 32'(out_bin), 32'(m_bin));
    endtask

    initial begin
        logic [W-1:0] c;
        logic [W-1:0] eb;
        logic         ee;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_gray   = '0;
        out_ready = 1'b0;
        model_reset();
        tick();
        tick();
        do_reset();

        do_code(4'b0110, 0);

        do_reset();
        for (int i = 0; i < 16; i++) begin
            c = W'(i ^ (i >> 1));
            do_code(c, 0);
        end

        do_reset();
        do_code(4'b0000, 0);
        do_code(4'b0011, 0);
        do_code(4'b0011, 1);

        do_code(4'b1000, 5);

        in_valid = 1'b1;
        in_gray  = 4'b1010;
        tick();
        model_accept(4'b1010, eb, ee);
        in_valid = 1'b0;
        tick();
        tick();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("no_ghost_valid", 32'(out_valid), 32'd0);
        end
        do_code(4'b1111, 0);

        do_reset();
        do_code(4'b1000, 0);
        do_code(4'b0000, 0);

        c = '0;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1)
                c = c ^ W'(1 << $urandom_range(0, W - 1));
            else
                c = W'($urandom);
            do_code(c, int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
